// File: rtl/tx_frame_scheduler_pkg.sv
// Shared link definitions: state encoding, K28.5 byte and frame bit positions.
// Used by both the transmit scheduler and the receive-side deframer.
package tx_frame_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [7:0] K28_5 = 8'hBC;

    localparam int FRAME_MARK_BIT   = 7;
    localparam int FRAME_LOCK_BIT   = 6;
    localparam int FRAME_MASTER_BIT = 5;
    localparam int FRAME_DATA_MSB   = 4;
    localparam int FRAME_DATA_LSB   = 1;
    localparam int FRAME_PARITY_BIT = 0;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } sym_t;

    // Parity bit chosen so that the whole byte XORs to 1 (odd parity).
    function automatic logic odd_parity(input logic [6:0] body);
        return ~(^body);
    endfunction

endpackage

// File: rtl/tx_frame_pack.sv
// Combinational formation of a data frame byte: marker, lock, master,
// four channel bits and an odd-parity bit.
module tx_frame_pack
    import tx_frame_scheduler_pkg::*;
(
    input  logic [3:0] i_data,
    input  logic       i_local_lock,
    input  logic       i_master,
    output logic [7:0] o_byte
);

    logic [7:0] w_byte;

    always_comb begin
        w_byte                                  = '0;
        w_byte[FRAME_MARK_BIT]                  = 1'b1;
        w_byte[FRAME_LOCK_BIT]                  = i_local_lock;
        w_byte[FRAME_MASTER_BIT]                = i_master;
        w_byte[FRAME_DATA_MSB:FRAME_DATA_LSB]   = i_data;
        w_byte[FRAME_PARITY_BIT]                = odd_parity(w_byte[FRAME_MARK_BIT:FRAME_DATA_LSB]);
    end

    assign o_byte = w_byte;

endmodule

// File: rtl/tx_frame_scheduler.sv
// Link transmit sequencer: IDLE/TRAIN/RUN state machine answering symbol
// requests from the serializer with K28.5 commas or packed data frames.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int TRAIN_LEN    = 16,
    parameter int COMMA_PERIOD = 4
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_en,
    input  logic       i_retrain,
    input  logic [3:0] i_data,
    input  logic       i_local_lock,
    input  logic       i_master,
    input  logic       i_sym_req,
    output logic       o_sym_valid,
    output logic       o_sym_k,
    output logic [7:0] o_sym_data,
    output logic [1:0] o_state,
    output logic       o_overrun
);

    logic [1:0] r_state;
    logic [7:0] r_train_cnt;
    logic [3:0] r_slot;
    logic       r_acc_prev;
    logic       r_valid;
    sym_t       r_sym;
    logic       r_overrun;

    logic       w_req_acc;
    logic       w_req_drop;
    logic       w_sym_k;
    logic [7:0] w_frame;

    // A request directly behind an accepted one is an overrun and is dropped.
    assign w_req_acc  = i_sym_req & ~r_acc_prev;
    assign w_req_drop = i_sym_req &  r_acc_prev;

    // Symbol type comes from the state before any change made on this cycle.
    assign w_sym_k = (r_state != ST_RUN) || (r_slot == 4'd0);

    tx_frame_pack u_pack (
        .i_data       (i_data),
        .i_local_lock (i_local_lock),
        .i_master     (i_master),
        .o_byte       (w_frame)
    );

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state     <= ST_IDLE;
            r_train_cnt <= '0;
            r_slot      <= '0;
            r_acc_prev  <= 1'b0;
            r_valid     <= 1'b0;
            r_sym.k     <= 1'b1;
            r_sym.data  <= K28_5;
            r_overrun   <= 1'b0;
        end else begin
            r_valid    <= w_req_acc;
            r_acc_prev <= w_req_acc;

            if (w_req_acc) begin
                r_sym.k    <= w_sym_k;
                r_sym.data <= w_sym_k ? K28_5 : w_frame;
            end

            if (w_req_drop) begin
                r_overrun <= 1'b1;
            end

            if (!i_en) begin
                r_state     <= ST_IDLE;
                r_train_cnt <= '0;
                r_slot      <= '0;
            end else if (i_retrain && (r_state != ST_IDLE)) begin
                r_state     <= ST_TRAIN;
                r_train_cnt <= '0;
                r_slot      <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state     <= ST_TRAIN;
                        r_train_cnt <= '0;
                        r_slot      <= '0;
                    end
                    ST_TRAIN: begin
                        if (w_req_acc) begin
                            if (r_train_cnt == 8'(TRAIN_LEN - 1)) begin
                                r_state     <= ST_RUN;
                                r_train_cnt <= '0;
                                r_slot      <= '0;
                            end else begin
                                r_train_cnt <= r_train_cnt + 8'd1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_req_acc) begin
                            r_slot <= (r_slot == 4'(COMMA_PERIOD - 1)) ? 4'd0 : r_slot + 4'd1;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_train_cnt <= '0;
                        r_slot      <= '0;
                    end
                endcase
            end
        end
    end

    assign o_sym_valid = r_valid;
    assign o_sym_k     = r_sym.k;
    assign o_sym_data  = r_sym.data;
    assign o_state     = r_state;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: stimulus queues hand-computed
// symbols, a negedge monitor pops and checks them against the DUT outputs.
module tb_tx_frame_scheduler;

    logic       clk = 1'b0;
    logic       i_res = 1'b1;
    logic       i_en = 1'b0;
    logic       i_retrain = 1'b0;
    logic [3:0] i_data = 4'd0;
    logic       i_local_lock = 1'b0;
    logic       i_master = 1'b0;
    logic       i_sym_req = 1'b0;
    logic       o_sym_valid;
    logic       o_sym_k;
    logic [7:0] o_sym_data;
    logic [1:0] o_state;
    logic       o_overrun;

    always #8 clk = ~clk;

    tx_frame_scheduler #(.TRAIN_LEN(16), .COMMA_PERIOD(4)) dut (
        .i_clk        (clk),
        .i_res        (i_res),
        .i_en         (i_en),
        .i_retrain    (i_retrain),
        .i_data       (i_data),
        .i_local_lock (i_local_lock),
        .i_master     (i_master),
        .i_sym_req    (i_sym_req),
        .o_sym_valid  (o_sym_valid),
        .o_sym_k      (o_sym_k),
        .o_sym_data   (o_sym_data),
        .o_state      (o_state),
        .o_overrun    (o_overrun)
    );

    typedef struct {
        logic       k;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic res_at_edge = 1'b1;
    logic model_k = 1'b1;
    logic [7:0] model_d = 8'hBC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        res_at_edge <= i_res;
    end

    // Monitor: reset values, scoreboard pops on valid, hold check otherwise.
    always @(negedge clk) begin
        if (res_at_edge) begin
            check("reset_valid", {31'd0, o_sym_valid}, 32'd0);
            check("reset_k", {31'd0, o_sym_k}, 32'd1);
            check("reset_data", {24'd0, o_sym_data}, 32'hBC);
            check("reset_state", {30'd0, o_state}, 32'd0);
            check("reset_overrun", {31'd0, o_overrun}, 32'd0);
            model_k <= 1'b1;
            model_d <= 8'hBC;
        end else if (o_sym_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("[TB] sym cyc=%0d k=%0b data=%02h (exp k=%0b data=%02h)",
                         cyc, o_sym_k, o_sym_data, e.k, e.d);
                check("sym_latency", cyc, e.cyc);
                check("sym_k", {31'd0, o_sym_k}, {31'd0, e.k});
                check("sym_data", {24'd0, o_sym_data}, {24'd0, e.d});
                model_k <= o_sym_k;
                model_d <= o_sym_data;
            end
        end else begin
            check("hold_k", {31'd0, o_sym_k}, {31'd0, model_k});
            check("hold_data", {24'd0, o_sym_data}, {24'd0, model_d});
        end
    end

    task automatic push(input logic k, input logic [7:0] d);
        exp_t e;
        e.k   = k;
        e.d   = k ? 8'hBC : d;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    // One request on the next negedge, then `gap` idle cycles.
    task automatic req(input logic k, input logic [7:0] d, input int gap);
        @(negedge clk);
        i_sym_req = 1'b1;
        push(k, d);
        @(negedge clk);
        i_sym_req = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] d, input logic lock, input logic mst);
        i_data       = d;
        i_local_lock = lock;
        i_master     = mst;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        i_res = 1'b0;
        @(negedge clk);
        check("idle_state", {30'd0, o_state}, 32'd0);
        check("idle_overrun", {31'd0, o_overrun}, 32'd0);

        // Training then K,D,D,D pattern at 30-clock request spacing
        i_en = 1'b1;
        @(negedge clk);
        check("enter_train", {30'd0, o_state}, 32'd1);
        set_in(4'b1010, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) req(1'b1, 8'hBC, 28);
        check("still_train", {30'd0, o_state}, 32'd1);
        req(1'b1, 8'hBC, 28);
        check("enter_run", {30'd0, o_state}, 32'd2);
        for (int i = 0; i < 2; i++) begin
            req(1'b1, 8'hBC, 28);
            req(1'b0, 8'hD5, 28);
            req(1'b0, 8'hD5, 28);
            req(1'b0, 8'hD5, 28);
        end

        // Inputs sampled on the request cycle only
        req(1'b1, 8'hBC, 4);
        @(negedge clk);
        set_in(4'b0101, 1'b0, 1'b1);
        i_sym_req = 1'b1;
        push(1'b0, 8'hAB);
        @(negedge clk);
        i_sym_req = 1'b0;
        set_in(4'b1111, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        req(1'b0, 8'hFE, 4);
        set_in(4'b0000, 1'b0, 1'b0);
        req(1'b0, 8'h80, 4);

        // Retrain coinciding with a slot-2 request
        req(1'b1, 8'hBC, 4);
        req(1'b0, 8'h80, 4);
        @(negedge clk);
        i_sym_req = 1'b1;
        i_retrain = 1'b1;
        push(1'b0, 8'h80);
        @(negedge clk);
        i_sym_req = 1'b0;
        i_retrain = 1'b0;
        check("retrain_state", {30'd0, o_state}, 32'd1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) req(1'b1, 8'hBC, 4);
        check("retrain_run", {30'd0, o_state}, 32'd2);
        req(1'b1, 8'hBC, 4);
        req(1'b0, 8'h80, 4);

        // Back-to-back requests: second dropped, overrun sticky
        @(negedge clk);
        i_sym_req = 1'b1;
        push(1'b0, 8'h80);
        @(negedge clk);
        @(negedge clk);
        i_sym_req = 1'b0;
        check("overrun_set", {31'd0, o_overrun}, 32'd1);
        repeat (4) @(negedge clk);
        req(1'b0, 8'h80, 4);
        req(1'b1, 8'hBC, 4);
        check("overrun_held", {31'd0, o_overrun}, 32'd1);

        // Reset mid-RUN together with a request
        @(negedge clk);
        i_res     = 1'b1;
        i_sym_req = 1'b1;
        @(negedge clk);
        i_res     = 1'b0;
        i_sym_req = 1'b0;
        check("rst_run_overrun", {31'd0, o_overrun}, 32'd0);
        @(negedge clk);
        check("rst_run_retrain", {30'd0, o_state}, 32'd1);

        // Disable mid-TRAIN clears counters; retrain ignored in IDLE
        for (int i = 0; i < 3; i++) req(1'b1, 8'hBC, 4);
        i_en = 1'b0;
        @(negedge clk);
        check("disable_idle", {30'd0, o_state}, 32'd0);
        i_retrain = 1'b1;
        @(negedge clk);
        i_retrain = 1'b0;
        @(negedge clk);
        check("retrain_in_idle", {30'd0, o_state}, 32'd0);
        req(1'b1, 8'hBC, 4);
        i_en = 1'b1;
        @(negedge clk);
        check("reenable_train", {30'd0, o_state}, 32'd1);
        set_in(4'b1010, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) req(1'b1, 8'hBC, 4);
        check("reenable_run", {30'd0, o_state}, 32'd2);
        req(1'b1, 8'hBC, 4);
        req(1'b0, 8'hD5, 4);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
